slot_reels: RTL and testbench

//  Reel generator for the slot machine: produces the four 4-bit reel symbols consumed by the bank.
//  - A spin request starts a free-running LFSR draw; reels freeze one after another (staggered).
//  - Final symbols are held stable and flagged with a one-cycle result_valid pulse plus a jackpot flag.
//  - Sits between the spin button debouncer and the bank/display logic.

---
 rtl/slot_pkg.sv | 26 ++
 rtl/slot_lfsr.sv | 32 +++
 rtl/slot_reels.sv | 112 +++++++++++
 tb/tb_slot_reels.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine reel generator.
package slot_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StSpin = 2'd1;
  localparam state_t StDone = 2'd2;

  localparam int unsigned DefaultSymbols = 10;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Distinct power-on symbols so the bank never sees a false match before the first spin.
  localparam logic [3:0] RstSym [4] = '{4'd0, 4'd1, 4'd2, 4'd3};

  // Fold a raw nibble into 0..symbols-1; eight passes covers symbols=2 with raw=15.
  function automatic logic [3:0] map_symbol(input logic [3:0] raw, input int unsigned symbols);
    logic [4:0] v;
    v = {1'b0, raw};
    for (int unsigned k = 0; k < 8; k++) begin
      if (v >= 5'(symbols)) v = v - 5'(symbols);
    end
    return v[3:0];
  endfunction

endpackage

// File: rtl/slot_lfsr.sv
// 16-bit Galois LFSR that free-runs every cycle and reloads its seed if it ever reads zero.
module slot_lfsr
  import slot_pkg::*;
#(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [15:0] lfsr_o
);

  logic [15:0] lfsr_d, lfsr_q;

  always_comb begin
    if (lfsr_q == 16'h0) begin
      lfsr_d = Seed;
    end else begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrTaps : 16'h0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/slot_reels.sv
// Four-reel symbol generator: a spin edge starts an LFSR draw, reels freeze in staggered order,
// then a one-cycle result_valid pulse reports the final symbols and the jackpot flag.
module slot_reels
  import slot_pkg::*;
#(
  parameter int unsigned SYMBOLS     = DefaultSymbols,
  parameter int unsigned SPIN_CYCLES = 16,
  parameter int unsigned STAGGER     = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spin,
  output logic [3:0] randNum1,
  output logic [3:0] randNum2,
  output logic [3:0] randNum3,
  output logic [3:0] randNum4,
  output logic       spinning,
  output logic [3:0] reel_stop,
  output logic       result_valid,
  output logic       jackpot
);

  localparam int unsigned LastCnt = SPIN_CYCLES + 3 * STAGGER;
  localparam int unsigned CntW    = $clog2(LastCnt + 2);

  state_t            state_d, state_q;
  logic [CntW-1:0]   cnt_d, cnt_q;
  logic [3:0]        reel_d [4];
  logic [3:0]        reel_q [4];
  logic [3:0]        stop_d, stop_q;
  logic              valid_d, valid_q;
  logic              jackpot_d, jackpot_q;
  logic              spin_prev_q;
  logic [15:0]       lfsr;

  slot_lfsr #(
    .Seed(LFSR_SEED)
  ) u_lfsr (
    .clk_i (clk),
    .rst_ni(rst_n),
    .lfsr_o(lfsr)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    reel_d    = reel_q;
    stop_d    = stop_q;
    valid_d   = 1'b0;
    jackpot_d = jackpot_q;
    case (state_q)
      StIdle: begin
        if (spin && !spin_prev_q) begin
          state_d   = StSpin;
          cnt_d     = '0;
          stop_d    = '0;
          jackpot_d = 1'b0;
        end
      end
      StSpin: begin
        cnt_d = cnt_q + CntW'(1);
        // Reel i keeps drawing until its own threshold, then holds and reports stopped.
        for (int unsigned i = 0; i < 4; i++) begin
          if (cnt_q < CntW'(SPIN_CYCLES + i * STAGGER)) begin
            reel_d[i] = map_symbol(lfsr[4*i +: 4], SYMBOLS);
          end else begin
            stop_d[i] = 1'b1;
          end
        end
        if (cnt_q == CntW'(LastCnt)) state_d = StDone;
      end
      StDone: begin
        valid_d   = 1'b1;
        jackpot_d = (reel_q[0] == reel_q[1]) && (reel_q[1] == reel_q[2]) &&
                    (reel_q[2] == reel_q[3]);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      reel_q      <= RstSym;
      stop_q      <= '0;
      valid_q     <= 1'b0;
      jackpot_q   <= 1'b0;
      spin_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reel_q      <= reel_d;
      stop_q      <= stop_d;
      valid_q     <= valid_d;
      jackpot_q   <= jackpot_d;
      spin_prev_q <= spin;
    end
  end

  assign randNum1     = reel_q[0];
  assign randNum2     = reel_q[1];
  assign randNum3     = reel_q[2];
  assign randNum4     = reel_q[3];
  assign spinning     = (state_q == StSpin);
  assign reel_stop    = stop_q;
  assign result_valid = valid_q;
  assign jackpot      = jackpot_q;

endmodule

// File: tb/tb_slot_reels.sv
// Scoreboard bench for slot_reels: a default instance plus a STAGGER=0 instance seeded for a jackpot.
module tb_slot_reels;

  localparam int unsigned Sym    = 10;
  localparam int unsigned SpinC  = 16;
  localparam int unsigned Stag   = 8;
  localparam int unsigned Last   = SpinC + 3 * Stag;
  localparam logic [15:0] Seed   = 16'hACE1;
  localparam logic [15:0] Taps   = 16'hB400;
  localparam int unsigned SpinC2 = 4;
  localparam int unsigned Stag2  = 0;
  localparam int unsigned Last2  = SpinC2 + 3 * Stag2;

  // Walk the Galois sequence backwards so the state four steps after reset is 16'hCCCC.
  function automatic logic [15:0] lfsr_back(input logic [15:0] n, input int unsigned k);
    logic [15:0] s, t;
    logic        b;
    s = n;
    for (int unsigned j = 0; j < k; j++) begin
      b = s[15];
      t = b ? (s ^ Taps) : s;
      s = {t[14:0], b};
    end
    return s;
  endfunction

  localparam logic [15:0] JpSeed = lfsr_back(16'hCCCC, 4);

  function automatic logic [15:0] lfsr_step(input logic [15:0] s, input logic [15:0] seed);
    logic [15:0] n;
    if (s == 16'h0) return seed;
    n = s >> 1;
    if (s[0]) n = n ^ Taps;
    return n;
  endfunction

  // Final symbols {r4,r3,r2,r1} given the LFSR value present at the start edge.
  function automatic logic [15:0] predict(input logic [15:0] l0, input logic [15:0] seed,
                                          input int unsigned spc, input int unsigned stg);
    logic [15:0] s, res;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      s = l0;
      for (int unsigned j = 0; j < spc + i * stg; j++) s = lfsr_step(s, seed);
      res[4*i +: 4] = 4'(32'(s[4*i +: 4]) % Sym);
    end
    return res;
  endfunction

  typedef struct {
    logic [15:0] syms;
    logic        jp;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];

  logic clk = 1'b0;
  logic rst_n, spin, rst2_n, spin2;
  logic [3:0] r1, r2, r3, r4, q1, q2, q3, q4;
  logic spinning, result_valid, jackpot, spinning2, result_valid2, jackpot2;
  logic [3:0] reel_stop, reel_stop2;
  logic [15:0] m_lfsr, m_lfsr2;
  int unsigned edge_cnt = 0;
  int checks = 0;
  int errors = 0;

  slot_reels u_dut (
    .clk(clk), .rst_n(rst_n), .spin(spin),
    .randNum1(r1), .randNum2(r2), .randNum3(r3), .randNum4(r4),
    .spinning(spinning), .reel_stop(reel_stop), .result_valid(result_valid), .jackpot(jackpot)
  );

  slot_reels #(
    .SYMBOLS(Sym), .SPIN_CYCLES(SpinC2), .STAGGER(Stag2), .LFSR_SEED(JpSeed)
  ) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .spin(spin2),
    .randNum1(q1), .randNum2(q2), .randNum3(q3), .randNum4(q4),
    .spinning(spinning2), .reel_stop(reel_stop2), .result_valid(result_valid2),
    .jackpot(jackpot2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= Seed;
    else        m_lfsr <= lfsr_step(m_lfsr, Seed);
  end

  always @(posedge clk or negedge rst2_n) begin
    if (!rst2_n) m_lfsr2 <= JpSeed;
    else         m_lfsr2 <= lfsr_step(m_lfsr2, JpSeed);
  end

  function automatic logic all_eq(input logic [15:0] s);
    return (s[3:0] == s[7:4]) && (s[7:4] == s[11:8]) && (s[11:8] == s[15:12]);
  endfunction

  // Call at a negedge: raises spin and records the expected outcome.
  task automatic start_spin();
    exp_t e;
    spin   = 1'b1;
    e.syms = predict(m_lfsr, Seed, SpinC, Stag);
    e.jp   = all_eq(e.syms);
    e.due  = edge_cnt + 1 + Last + 2;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; spin = 1'b0; rst2_n = 1'b0; spin2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({r4, r3, r2, r1} !== 16'h3210) begin
      errors++; $display("FAIL reset_syms got %h want 3210", {r4, r3, r2, r1});
    end
    checks++;
    if ({spinning, reel_stop, result_valid, jackpot} !== 7'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000000",
                         {spinning, reel_stop, result_valid, jackpot});
    end
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({r4, r3, r2, r1, q4, q3, q2, q1} !== 32'h3210_3210) begin
      errors++; $display("FAIL idle_syms got %h want 32103210", {r4, r3, r2, r1, q4, q3, q2, q1});
    end
    checks++;
    if ({spinning, reel_stop, result_valid, jackpot, spinning2, reel_stop2, result_valid2,
         jackpot2} !== 14'b0) begin
      errors++; $display("FAIL idle_flags got %b want 0", {spinning, reel_stop, result_valid,
                         jackpot, spinning2, reel_stop2, result_valid2, jackpot2});
    end
  endtask

  task automatic test_single_spin();
    exp_t e;
    int unsigned start, k;
    logic [3:0] exp_stop;
    logic [15:0] want;
    spin = 1'b0;
    repeat (2) @(negedge clk);
    start = edge_cnt + 1;
    start_spin();
    want = sb[sb.size() - 1].syms;
    for (int c = 0; c < int'(Last) + 6; c++) begin
      @(negedge clk);
      k = edge_cnt - start;
      if (c == 2) spin = 1'b0;
      for (int unsigned i = 0; i < 4; i++) exp_stop[i] = (k >= SpinC + i * Stag + 1);
      checks++;
      if ({spinning, reel_stop, result_valid} !== {(k <= Last), exp_stop, (k == Last + 2)}) begin
        errors++; $display("FAIL timeline k=%0d got %b want %b", k,
                           {spinning, reel_stop, result_valid},
                           {(k <= Last), exp_stop, (k == Last + 2)});
      end
      if (result_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL single_extra got result_valid want none");
        end else begin
          e = sb.pop_front();
          if ({r4, r3, r2, r1, jackpot} !== {e.syms, e.jp}) begin
            errors++; $display("FAIL single_syms got %h/%b want %h/%b", {r4, r3, r2, r1},
                               jackpot, e.syms, e.jp);
          end
        end
      end
    end
    sb.delete();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if ({r4, r3, r2, r1} !== want) begin
        errors++; $display("FAIL hold_syms got %h want %h", {r4, r3, r2, r1}, want);
      end
    end
  endtask

  task automatic test_held_spin();
    exp_t e;
    int pulses;
    spin = 1'b0;
    repeat (2) @(negedge clk);
    for (int round = 0; round < 2; round++) begin
      start_spin();
      pulses = 0;
      for (int c = 0; c < (round == 0 ? 200 : int'(Last) + 10); c++) begin
        @(negedge clk);
        if (result_valid) begin
          pulses++;
          if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if ({r4, r3, r2, r1, jackpot} !== {e.syms, e.jp} || edge_cnt !== e.due) begin
              errors++; $display("FAIL held_result got %h/%b@%0d want %h/%b@%0d",
                                 {r4, r3, r2, r1}, jackpot, edge_cnt, e.syms, e.jp, e.due);
            end
          end
        end
      end
      checks++;
      if (pulses !== 1) begin
        errors++; $display("FAIL held_pulses round=%0d got %0d want 1", round, pulses);
      end
      sb.delete();
      spin = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_pulse();
    exp_t e;
    int pulses;
    int unsigned start, k;
    spin = 1'b0;
    repeat (2) @(negedge clk);
    start = edge_cnt + 1;
    start_spin();
    @(negedge clk);
    spin = 1'b0;
    pulses = 0;
    for (int c = 0; c < int'(Last) + 30; c++) begin
      @(negedge clk);
      k = edge_cnt - start;
      if (k == 9) spin = 1'b1;
      if (k == 10) spin = 1'b0;
      if (result_valid) begin
        pulses++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          if ({r4, r3, r2, r1} !== e.syms || edge_cnt !== e.due) begin
            errors++; $display("FAIL ignored_result got %h@%0d want %h@%0d",
                               {r4, r3, r2, r1}, edge_cnt, e.syms, e.due);
          end
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL ignored_pulses got %0d want 1", pulses);
    end
    sb.delete();
  endtask

  task automatic test_reset_mid_spin();
    exp_t e;
    int pulses;
    spin = 1'b0;
    repeat (2) @(negedge clk);
    start_spin();
    @(negedge clk);
    spin = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({r4, r3, r2, r1, spinning, reel_stop, result_valid, jackpot} !== {16'h3210, 7'b0}) begin
      errors++; $display("FAIL abort_outputs got %h want %h",
                         {r4, r3, r2, r1, spinning, reel_stop, result_valid, jackpot},
                         {16'h3210, 7'b0});
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < int'(Last) + 10; c++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL abort_pulses got %0d want 0", pulses);
    end
    start_spin();
    pulses = 0;
    for (int c = 0; c < int'(Last) + 10; c++) begin
      @(negedge clk);
      if (c == 2) spin = 1'b0;
      if (result_valid) begin
        pulses++;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checks++;
          if ({r4, r3, r2, r1, jackpot} !== {e.syms, e.jp} || edge_cnt !== e.due) begin
            errors++; $display("FAIL after_abort got %h/%b@%0d want %h/%b@%0d",
                               {r4, r3, r2, r1}, jackpot, edge_cnt, e.syms, e.jp, e.due);
          end
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL after_abort_pulses got %0d want 1", pulses);
    end
    sb.delete();
  endtask

  task automatic test_jackpot();
    exp_t e;
    int pulses;
    int unsigned start, k;
    @(negedge clk);
    rst2_n = 1'b0;
    spin2  = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    spin2  = 1'b1;
    start  = edge_cnt + 1;
    e.syms = 16'h2222;
    e.jp   = 1'b1;
    e.due  = start + Last2 + 2;
    sb2.push_back(e);
    pulses = 0;
    for (int c = 0; c < int'(Last2) + 6; c++) begin
      @(negedge clk);
      k = edge_cnt - start;
      checks++;
      if (reel_stop2 !== ((k >= SpinC2 + 1) ? 4'hF : 4'h0)) begin
        errors++; $display("FAIL stagger0_stop k=%0d got %b want %b", k, reel_stop2,
                           ((k >= SpinC2 + 1) ? 4'hF : 4'h0));
      end
      if (result_valid2) begin
        pulses++;
        if (sb2.size() != 0) begin
          e = sb2.pop_front();
          checks++;
          if ({q4, q3, q2, q1, jackpot2} !== {e.syms, e.jp} || edge_cnt !== e.due) begin
            errors++; $display("FAIL jackpot_result got %h/%b@%0d want %h/%b@%0d",
                               {q4, q3, q2, q1}, jackpot2, edge_cnt, e.syms, e.jp, e.due);
          end
        end
      end
    end
    checks++;
    if (pulses !== 1 || jackpot2 !== 1'b1) begin
      errors++; $display("FAIL jackpot_hold got pulses=%0d jp=%b want pulses=1 jp=1",
                         pulses, jackpot2);
    end
    spin2 = 1'b0;
    @(negedge clk);
    spin2  = 1'b1;
    e.syms = predict(m_lfsr2, JpSeed, SpinC2, Stag2);
    e.jp   = all_eq(e.syms);
    e.due  = edge_cnt + 1 + Last2 + 2;
    sb2.push_back(e);
    @(negedge clk);
    checks++;
    if (jackpot2 !== 1'b0 || spinning2 !== 1'b1) begin
      errors++; $display("FAIL jackpot_clear got jp=%b spin=%b want jp=0 spin=1",
                         jackpot2, spinning2);
    end
    pulses = 0;
    for (int c = 0; c < int'(Last2) + 8; c++) begin
      @(negedge clk);
      if (result_valid2) begin
        pulses++;
        if (sb2.size() != 0) begin
          e = sb2.pop_front();
          checks++;
          if ({q4, q3, q2, q1, jackpot2} !== {e.syms, e.jp} || edge_cnt !== e.due) begin
            errors++; $display("FAIL respin_result got %h/%b@%0d want %h/%b@%0d",
                               {q4, q3, q2, q1}, jackpot2, edge_cnt, e.syms, e.jp, e.due);
          end
        end
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL respin_pulses got %0d want 1", pulses);
    end
    spin2 = 1'b0;
    sb2.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_spin();
    test_held_spin();
    test_ignored_pulse();
    test_jackpot();
    test_reset_mid_spin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
